// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - shared Kronos pipeline types and constants
package kronos_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    localparam logic [31:0] ZERO = 32'h0000_0000;
    localparam logic [31:0] FOUR = 32'h0000_0004;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/kronos_skid_buffer.sv
// rtl/kronos_skid_buffer.sv - 2-entry FIFO with registered head and flush
module kronos_skid_buffer #(
    parameter type T = logic [63:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  T           push_data,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output T           head
);

    T           entry1;
    logic       do_pop;
    logic [1:0] slot;

    assign do_pop = pop && (count != 2'd0);
    // Slot the incoming word lands in once any same-cycle pop has shifted the buffer
    assign slot   = count - 2'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head   <= '0;
            entry1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                head <= entry1;
            end
            if (push) begin
                if (slot == 2'd0) begin
                    head <= push_data;
                end else begin
                    entry1 <= push_data;
                end
            end
            count <= count + 2'(push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/kronos_fetch.sv
// rtl/kronos_fetch.sv - Kronos instruction-fetch stage with redirect flush
module kronos_fetch
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic        instr_req,
    input  logic        instr_ack,
    output logic [63:0] fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy,
    input  logic        branch,
    input  logic [31:0] branch_target
);

    fetch_state_e state;
    logic [31:0]  pc_fetch;
    logic [31:0]  pc_inc;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         push;
    logic         pop;
    logic         flush;
    pipeIFID_t    head;
    pipeIFID_t    push_data;

    assign fetch_vld  = (count != 2'd0);
    assign fetch      = head;
    assign pop        = fetch_vld && fetch_rdy;
    assign push       = (state == FETCH) && instr_ack && !branch;
    assign flush      = branch && (state != INIT);
    assign pc_inc     = pc_fetch + FOUR;
    assign count_next = count + 2'(push) - 2'(pop);
    assign push_data  = '{pc: pc_fetch, ir: instr_data};

    kronos_skid_buffer #(
        .T(pipeIFID_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .count    (count),
        .head     (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            pc_fetch   <= BOOT_ADDR;
            instr_req  <= 1'b0;
            instr_addr <= word_align(BOOT_ADDR);
        end else begin
            case (state)
                INIT: begin
                    state     <= FETCH;
                    instr_req <= 1'b1;
                    if (branch) begin
                        pc_fetch   <= branch_target;
                        instr_addr <= word_align(branch_target);
                    end else begin
                        instr_addr <= word_align(pc_fetch);
                    end
                end
                FETCH: begin
                    if (branch) begin
                        pc_fetch <= branch_target;
                        if (instr_ack) begin
                            instr_addr <= word_align(branch_target);
                        end else begin
                            // Bus cannot abort: keep the old address until its ack arrives
                            state <= FLUSH;
                        end
                    end else if (instr_ack) begin
                        pc_fetch   <= pc_inc;
                        instr_addr <= word_align(pc_inc);
                        if (count_next == 2'd2) begin
                            state     <= STALL;
                            instr_req <= 1'b0;
                        end
                    end
                end
                STALL: begin
                    if (branch) begin
                        pc_fetch   <= branch_target;
                        instr_addr <= word_align(branch_target);
                        state      <= FETCH;
                        instr_req  <= 1'b1;
                    end else if (pop) begin
                        state     <= FETCH;
                        instr_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (branch) begin
                        pc_fetch <= branch_target;
                    end
                    if (instr_ack) begin
                        state      <= FETCH;
                        instr_addr <= word_align(branch ? branch_target : pc_fetch);
                    end
                end
                default: begin
                    state     <= INIT;
                    instr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_fetch.sv
// tb/tb_kronos_fetch.sv - self-checking bench for kronos_fetch
module tb_kronos_fetch;
    import kronos_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_req;
    logic        instr_ack = 1'b0;
    logic [63:0] fetch;
    logic        fetch_vld;
    logic        fetch_rdy = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_zero;
    } vec_t;

    vec_t        tbl[25];
    logic [63:0] sb[$];
    logic [31:0] exp_pc;
    logic [31:0] t;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic r, input logic a, input logic rd, input logic b,
                                input logic [31:0] tg, input logic c, input logic eq,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                                input logic ez);
        vec_t v;
        v.rst = r; v.ack = a; v.rdy = rd; v.br = b; v.tgt = tg; v.chk = c;
        v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep; v.e_zero = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    assign instr_data = mem_f(instr_addr);

    kronos_fetch #(
        .BOOT_ADDR(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr   (instr_addr),
        .instr_data   (instr_data),
        .instr_req    (instr_req),
        .instr_ack    (instr_ack),
        .fetch        (fetch),
        .fetch_vld    (fetch_vld),
        .fetch_rdy    (fetch_rdy),
        .branch       (branch),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    initial begin
        //               rst ack rdy br  tgt            chk req addr           vld pc             zero
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0);
        tbl[1]  = mk(1, 0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1);
        tbl[2]  = mk(0, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          0);
        tbl[3]  = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,          0);
        tbl[4]  = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h4,          1, 32'h0,          0);
        tbl[5]  = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,          1, 32'h4,          0);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,          1, 1, 32'hC,          1, 32'h8,          0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,          1, 0, 32'h10,         1, 32'h8,          0);
        tbl[8]  = mk(0, 0, 1, 0, 32'h0,          1, 0, 32'h10,         1, 32'h8,          0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h10,         1, 32'hC,          0);
        tbl[10] = mk(0, 0, 1, 1, 32'h100,        1, 1, 32'h10,         0, 32'h0,          0);
        tbl[11] = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h10,         0, 32'h0,          0);
        tbl[12] = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h10,         0, 32'h0,          0);
        tbl[13] = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h10,         0, 32'h0,          0);
        tbl[14] = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h100,        0, 32'h0,          0);
        tbl[15] = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h104,        1, 32'h100,        0);
        tbl[16] = mk(0, 1, 1, 1, 32'h200,        1, 1, 32'h104,        0, 32'h0,          0);
        tbl[17] = mk(0, 1, 1, 0, 32'h0,          1, 1, 32'h200,        0, 32'h0,          0);
        tbl[18] = mk(0, 1, 1, 1, 32'hFFFF_FFFC,  1, 1, 32'h204,        1, 32'h200,        0);
        tbl[19] = mk(0, 1, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0,          0);
        tbl[20] = mk(0, 1, 0, 0, 32'h0,          1, 1, 32'h0,          1, 32'hFFFF_FFFC,  0);
        tbl[21] = mk(1, 0, 0, 0, 32'h0,          1, 0, 32'h4,          1, 32'hFFFF_FFFC,  0);
        tbl[22] = mk(0, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1);
        tbl[23] = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,          0);
        tbl[24] = mk(0, 0, 1, 0, 32'h0,          1, 1, 32'h0,          0, 32'h0,          0);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("c%0d req", i), 64'(instr_req), 64'(tbl[i].e_req));
                check($sformatf("c%0d addr", i), 64'(instr_addr), 64'(tbl[i].e_addr));
                check($sformatf("c%0d vld", i), 64'(fetch_vld), 64'(tbl[i].e_vld));
                if (tbl[i].e_zero)
                    check($sformatf("c%0d fetch_zero", i), fetch, 64'h0);
                else if (tbl[i].e_vld)
                    check($sformatf("c%0d fetch", i), fetch, {tbl[i].e_pc, mem_f(tbl[i].e_pc)});
            end
            rst           = tbl[i].rst;
            instr_ack     = tbl[i].ack;
            fetch_rdy     = tbl[i].rdy;
            branch        = tbl[i].br;
            branch_target = tbl[i].tgt;
        end

        // Random traffic against a scoreboard of expected {pc, ir} in program order
        exp_pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            logic a, r, b;
            @(negedge clk);
            check("sb vld", 64'(fetch_vld), 64'(sb.size() != 0));
            if (sb.size() == 2)
                check("sb stall_req", 64'(instr_req), 64'h0);
            r = ($urandom_range(0, 3) != 0);
            a = instr_req && ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 15) == 0) && (!instr_req || a);
            t = $urandom();
            t[1:0] = 2'b00;
            if (fetch_vld && r && sb.size() != 0) begin
                check("sb fetch", fetch, sb[0]);
                void'(sb.pop_front());
            end
            if (a && !b) begin
                check("sb addr", 64'(instr_addr), 64'(exp_pc));
                sb.push_back({exp_pc, mem_f(exp_pc)});
                exp_pc = exp_pc + 32'h4;
            end
            if (b) begin
                sb.delete();
                exp_pc = t;
            end
            instr_ack     = a;
            fetch_rdy     = r;
            branch        = b;
            branch_target = t;
        end

        @(negedge clk);
        instr_ack = 1'b0;
        branch    = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
